// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot entrance gate controller.
package parking_pkg;

  localparam int N_SLOTS = 6;
  localparam int SLOT_W  = 3;
  localparam int COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    PASS  = 3'd2,
    CLOSE = 3'd3,
    DENY  = 3'd4
  } state_e;

  // Lowest-numbered clear bit; 0 when every slot is occupied.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [N_SLOTS-1:0] occ);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SLOT_W-1:0] count_free(input logic [N_SLOTS-1:0] occ);
    logic [SLOT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      n = n + {{(SLOT_W-1){1'b0}}, ~occ[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ir_debouncer.sv
// Two-flop synchroniser and level debouncer for the entrance IR beam,
// with a one-cycle rising-edge strobe on the debounced level.
module ir_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ir_i,
  output logic ir_db_o,
  output logic ir_rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q;
  logic             ir_s_q;
  logic             ir_db_q, ir_db_d;
  logic             ir_db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // debounced one, so any agreement restarts the qualification window.
  always_comb begin
    cnt_d   = '0;
    ir_db_d = ir_db_q;
    if (ir_s_q != ir_db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) ir_db_d = ~ir_db_q;
      else                                      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      ir_s_q      <= 1'b0;
      ir_db_q     <= 1'b0;
      ir_db_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= ir_i;
      ir_s_q      <= sync1_q;
      ir_db_q     <= ir_db_d;
      ir_db_dly_q <= ir_db_q;
      cnt_q       <= cnt_d;
    end
  end

  assign ir_db_o   = ir_db_q;
  assign ir_rise_o = ir_db_q & ~ir_db_dly_q;

endmodule

// File: rtl/gate_sequencer.sv
// Entrance gate controller: admits or refuses cars on a debounced beam rise,
// assigns the lowest free slot and walks the gate through open/hold/close.
module gate_sequencer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int CLOSE_CYCLES    = 6,
  parameter int OPEN_TIMEOUT    = 50
) (
  input  logic               clock_50MHz,
  input  logic               reset_n,
  input  logic               infrared_input,
  input  logic [N_SLOTS-1:0] pos,
  output logic               open_gate,
  output logic               deny,
  output logic               lot_full,
  output logic [SLOT_W-1:0]  free_count,
  output logic [SLOT_W-1:0]  assigned_slot,
  output logic               slot_valid,
  output logic               timeout_pulse,
  output logic [COUNT_W-1:0] entry_count
);

  localparam int TMR_MAX0 = (OPEN_TIMEOUT > HOLD_CYCLES) ? OPEN_TIMEOUT : HOLD_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > CLOSE_CYCLES) ? TMR_MAX0 : CLOSE_CYCLES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  logic               ir_db, ir_rise;
  logic [N_SLOTS-1:0] pos_sync_q, pos_s_q;
  logic [SLOT_W-1:0]  free_q;
  logic               lot_full_q;

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic               open_gate_q, deny_q, slot_valid_q, timeout_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [COUNT_W-1:0] entry_q;

  ir_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_i    (clock_50MHz),
    .rst_ni   (reset_n),
    .ir_i     (infrared_input),
    .ir_db_o  (ir_db),
    .ir_rise_o(ir_rise)
  );

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      pos_sync_q <= '0;
      pos_s_q    <= '0;
      free_q     <= '0;
      lot_full_q <= 1'b0;
    end else begin
      pos_sync_q <= pos;
      pos_s_q    <= pos_sync_q;
      free_q     <= count_free(pos_s_q);
      lot_full_q <= &pos_s_q;
    end
  end

  // Gate/deny outputs are registered decodes of the previous state, so they
  // trail the state register by one cycle; the admission latency budget
  // includes that stage.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      open_gate_q  <= 1'b0;
      deny_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      slot_q       <= '0;
      entry_q      <= '0;
    end else begin
      open_gate_q <= (state_q == OPEN) || (state_q == PASS);
      deny_q      <= (state_q == DENY);
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ir_rise) begin
            if (lot_full_q) begin
              state_q <= DENY;
            end else begin
              state_q      <= OPEN;
              slot_q       <= lowest_free(pos_s_q);
              slot_valid_q <= 1'b1;
              timer_q      <= '0;
            end
          end
        end
        OPEN: begin
          if (!ir_db) begin
            state_q <= PASS;
            timer_q <= '0;
          end else if (timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
            state_q      <= CLOSE;
            timer_q      <= '0;
            timeout_q    <= 1'b1;
            slot_valid_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        PASS: begin
          if (ir_db) begin
            state_q <= OPEN;
            timer_q <= '0;
          end else if (timer_q == TMR_W'(HOLD_CYCLES - 1)) begin
            state_q      <= CLOSE;
            timer_q      <= '0;
            slot_valid_q <= 1'b0;
            entry_q      <= entry_q + 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CLOSE: begin
          if (timer_q == TMR_W'(CLOSE_CYCLES - 1)) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DENY: begin
          if (!ir_db) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign open_gate     = open_gate_q;
  assign deny          = deny_q;
  assign lot_full      = lot_full_q;
  assign free_count    = free_q;
  assign assigned_slot = slot_q;
  assign slot_valid    = slot_valid_q;
  assign timeout_pulse = timeout_q;
  assign entry_count   = entry_q;

endmodule
